mc_ctrl: RTL and testbench
==========================

# mc_ctrl

Multi-cycle sequencer for the RV32I core datapath. It turns the single-cycle datapath (pc, imem, reg_file, alu, dmem, main_ctrl, branch_ctrl) into a multi-cycle machine: it gates the architectural write enables from main_ctrl, adds request/acknowledge handshakes to imem and dmem, and traps on illegal opcodes and memory timeouts. It also keeps the cycle and retired-instruction counters.

## Interface
Parameters:
- MEM_TIMEOUT, default 16: maximum number of wait cycles for imem_ack or dmem_ack before a fault; legal range ≥ 2.
- CNT_W, default 32: width of the performance counters.

Ports:
- clk  in  1  core clock
- rst  in  1  reset, synchronous, active-high
- run  in  1  level; high lets the core fetch new instructions
- imem_ack  in  1  instruction word valid at imem output this cycle
- dmem_ack  in  1  dmem access completes this cycle
- inst_op  in  7  opcode field, inst[6:0], of the instruction register
- reg_wr_i  in  1  reg_wr from main_ctrl
- mem_rd_i  in  1  mem_rd from main_ctrl
- mem_wr_i  in  1  mem_wr from main_ctrl
- imem_req  out  1  instruction fetch request
- ir_we  out  1  instruction register load enable
- pc_we  out  1  pc register load enable; loads the pc_sel mux output
- reg_wr_o  out  1  gated reg_file write enable
- mem_rd_o  out  1  gated dmem read enable
- mem_wr_o  out  1  gated dmem write enable
- retire  out  1  one-cycle pulse per completed instruction
- fault  out  1  sticky trap flag
- state_o  out  3  current state encoding
- cycle_cnt  out  CNT_W  active-cycle counter
- instret_cnt  out  CNT_W  retired-instruction counter

## Operation
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, FAULT=6. Encoding 7 is unreachable and decodes as FAULT.
- Reset values: state IDLE; every 1-bit output 0; counters 0; wait counter 0.
- IDLE: all enables 0. If run=1, go to FETCH.
- FETCH:
  - imem_req=1.
  - If imem_ack=1: ir_we=1 in the same cycle, then go to DECODE.
  - Otherwise the wait counter increments. If no ack arrives and wait == MEM_TIMEOUT-1, go to FAULT.
- DECODE: lasts one cycle.
  - If inst_op is not in {0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111}, go to FAULT.
  - Otherwise go to EXEC.
- EXEC: lasts one cycle. If mem_rd_i or mem_wr_i is set, go to MEM. Otherwise go to WB.
- MEM:
  - mem_rd_o=mem_rd_i and mem_wr_o=mem_wr_i, held until dmem_ack. A repeated store of the same address and data is harmless.
  - On dmem_ack, go to WB. Timeout behaves the same as in FETCH.
- WB: lasts one cycle.
  - reg_wr_o=reg_wr_i, pc_we=1, retire=1.
  - Next state: FETCH if run=1, otherwise IDLE.
- FAULT: all enables 0 and fault=1. Left only by rst.
- Wait counter: cleared on every entry to FETCH or MEM. Width is clog2(MEM_TIMEOUT).
- Outputs outside the states listed above are 0. reg_wr_o, mem_rd_o and mem_wr_o are never 1 outside WB and MEM respectively.
- cycle_cnt increments each cycle the state is not IDLE or FAULT. instret_cnt increments on retire. Both wrap modulo 2^CNT_W with no saturation.

## Timing
- Moore outputs, decoded from the state register only: imem_req, pc_we, retire, fault, state_o.
- Mealy outputs:
  - ir_we, from imem_ack.
  - reg_wr_o, mem_rd_o, mem_wr_o, from the main_ctrl inputs.
- Minimum latency per instruction, with ack arriving in the first request cycle:
  - Non-memory instruction: 4 cycles (FETCH, DECODE, EXEC, WB).
  - Load or store: 5 cycles.
- Each wait cycle adds 1 cycle to that latency.
- Boundary conditions:
  - Ack and timeout in the same cycle: ack wins.
  - Ack outside FETCH or MEM: ignored.
  - run falling mid-instruction: the instruction completes and retires, then the block goes to IDLE.
  - run rising in IDLE: FETCH on the next cycle.
- rst mid-instruction: next cycle is IDLE with all outputs 0. No partial write-back occurs after the reset cycle.
- Counter wrap, e.g. 0xFFFFFFFF → 0: no effect on sequencing.

## Test plan
- ADDI x1,x0,5 with immediate acks and run=1: states 1,2,3,5. reg_wr_o=1 and pc_we=1 only in the WB cycle, one retire pulse, instret_cnt=1, cycle_cnt=4.
- SW with dmem_ack delayed 3 cycles: MEM lasts 4 cycles with mem_wr_o=1 throughout, reg_wr_o stays 0, and WB follows the ack cycle.
- imem_ack never asserted, MEM_TIMEOUT=16: FAULT after 16 FETCH cycles, fault=1 stays set, and only rst clears it.
- Illegal opcode 0000000 in DECODE: FAULT next cycle, no retire, no pc_we.
- run dropped during EXEC of LW: the instruction retires, then state IDLE, imem_req=0, and cycle_cnt frozen.
- rst asserted during MEM: next cycle state=0, all outputs 0, both counters 0.

Source files
------------

// File: rtl/mc_ctrl.sv
// -----------------------------------------------------------------------------
// mc_ctrl -- multi-cycle sequencer for the RV32I core datapath
//
// Sequences the single-cycle datapath through the steps
// FETCH -> DECODE -> EXEC -> (MEM) -> WB. It gates the architectural write
// enables coming from main_ctrl, handshakes with imem/dmem, traps on illegal
// opcodes and memory timeouts, and keeps the cycle and retired-instruction
// counters.
//
// Parameters
//   MEM_TIMEOUT  maximum wait cycles for imem_ack / dmem_ack (>= 2)
//   CNT_W        width of the performance counters
//
// Ports
//   clk          core clock
//   rst          synchronous, active-high reset
//   run          level; high lets the core fetch new instructions
//   imem_ack     instruction word valid at imem output this cycle
//   dmem_ack     dmem access completes this cycle
//   inst_op      opcode field inst[6:0] of the instruction register
//   reg_wr_i     reg_wr from main_ctrl
//   mem_rd_i     mem_rd from main_ctrl
//   mem_wr_i     mem_wr from main_ctrl
//   imem_req     instruction fetch request            (Moore)
//   ir_we        instruction register load enable     (Mealy on imem_ack)
//   pc_we        pc register load enable              (Moore)
//   reg_wr_o     gated reg_file write enable          (Mealy on reg_wr_i)
//   mem_rd_o     gated dmem read enable               (Mealy on mem_rd_i)
//   mem_wr_o     gated dmem write enable              (Mealy on mem_wr_i)
//   retire       one-cycle pulse per completed instruction (Moore)
//   fault        sticky trap flag                     (Moore)
//   state_o      current state encoding               (Moore)
//   cycle_cnt    active-cycle counter
//   instret_cnt  retired-instruction counter
// -----------------------------------------------------------------------------
module mc_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             imem_ack,
    input  logic             dmem_ack,
    input  logic [6:0]       inst_op,
    input  logic             reg_wr_i,
    input  logic             mem_rd_i,
    input  logic             mem_wr_i,
    output logic             imem_req,
    output logic             ir_we,
    output logic             pc_we,
    output logic             reg_wr_o,
    output logic             mem_rd_o,
    output logic             mem_wr_o,
    output logic             retire,
    output logic             fault,
    output logic [2:0]       state_o,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);

    // Wait counter only has to reach MEM_TIMEOUT-1.
    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
    localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_FAULT  = 3'd6
    } state_t;

    // RV32I base opcodes accepted by the datapath.
    function automatic logic op_is_legal(input logic [6:0] op);
        case (op)
            7'b0110011,            // OP
            7'b0010011,            // OP-IMM
            7'b0000011,            // LOAD
            7'b0100011,            // STORE
            7'b1100011,            // BRANCH
            7'b1101111,            // JAL
            7'b1100111,            // JALR
            7'b0110111,            // LUI
            7'b0010111:            // AUIPC
                op_is_legal = 1'b1;
            default:
                op_is_legal = 1'b0;
        endcase
    endfunction

    state_t             state_q, state_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [CNT_W-1:0]   cycle_cnt_q, cycle_cnt_d;
    logic [CNT_W-1:0]   instret_cnt_q, instret_cnt_d;
    logic               active;

    // -------------------------------------------------------------------------
    // State register and counters
    // -------------------------------------------------------------------------
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge value of its peers; blocking here would create
    // order-dependent simulation and mismatch the synthesized netlist.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            wait_q        <= '0;
            cycle_cnt_q   <= '0;
            instret_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            wait_q        <= wait_d;
            cycle_cnt_q   <= cycle_cnt_d;
            instret_cnt_q <= instret_cnt_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;

        case (state_q)
            S_IDLE: begin
                if (run) begin
                    state_d = S_FETCH;
                    wait_d  = '0;
                end
            end

            S_FETCH: begin
                // Ack is tested before the timeout, so an ack on the last
                // permitted cycle still completes the fetch.
                if (imem_ack) begin
                    state_d = S_DECODE;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = S_FAULT;
                end else begin
                    wait_d = wait_q + WAIT_ONE;
                end
            end

            S_DECODE: begin
                state_d = op_is_legal(inst_op) ? S_EXEC : S_FAULT;
            end

            S_EXEC: begin
                if (mem_rd_i || mem_wr_i) begin
                    state_d = S_MEM;
                    wait_d  = '0;
                end else begin
                    state_d = S_WB;
                end
            end

            S_MEM: begin
                if (dmem_ack) begin
                    state_d = S_WB;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = S_FAULT;
                end else begin
                    wait_d = wait_q + WAIT_ONE;
                end
            end

            S_WB: begin
                // run is sampled only at instruction boundaries, so a drop
                // mid-instruction still lets the instruction retire.
                if (run) begin
                    state_d = S_FETCH;
                    wait_d  = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_FAULT: begin
                state_d = S_FAULT;
            end

            // Encoding 7 is unreachable; treat it as a trap.
            default: begin
                state_d = S_FAULT;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Output decode
    // -------------------------------------------------------------------------
    always_comb begin
        imem_req = 1'b0;
        ir_we    = 1'b0;
        pc_we    = 1'b0;
        reg_wr_o = 1'b0;
        mem_rd_o = 1'b0;
        mem_wr_o = 1'b0;
        retire   = 1'b0;
        fault    = 1'b0;
        active   = 1'b0;

        case (state_q)
            S_FETCH: begin
                imem_req = 1'b1;
                ir_we    = imem_ack;
                active   = 1'b1;
            end
            S_DECODE: begin
                active = 1'b1;
            end
            S_EXEC: begin
                active = 1'b1;
            end
            S_MEM: begin
                // Enables are held until dmem_ack; re-issuing the same store
                // while waiting is harmless.
                mem_rd_o = mem_rd_i;
                mem_wr_o = mem_wr_i;
                active   = 1'b1;
            end
            S_WB: begin
                reg_wr_o = reg_wr_i;
                pc_we    = 1'b1;
                retire   = 1'b1;
                active   = 1'b1;
            end
            S_IDLE: begin
                active = 1'b0;
            end
            default: begin
                // FAULT and the unreachable encoding 7.
                fault = 1'b1;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Performance counters (wrap silently)
    // -------------------------------------------------------------------------
    always_comb begin
        cycle_cnt_d   = active ? (cycle_cnt_q + CNT_ONE) : cycle_cnt_q;
        instret_cnt_d = retire ? (instret_cnt_q + CNT_ONE) : instret_cnt_q;
    end

    assign state_o     = state_q;
    assign cycle_cnt   = cycle_cnt_q;
    assign instret_cnt = instret_cnt_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mc_ctrl -- self-checking bench for mc_ctrl
//
// Instructions are described at transaction level (opcode, memory flags,
// fetch/memory ack delays, run at write-back, optional reset point) and
// expanded into a per-cycle script of phase + inputs. The expected outputs
// for each cycle follow from the phase and the inputs of that cycle; the
// counters are plain running sums over the script.
// -----------------------------------------------------------------------------
module tb_mc_ctrl;

    localparam int TO = 16;   // MEM_TIMEOUT
    localparam int CW = 6;    // small counter width so wrap is exercised

    localparam logic [2:0] P_IDLE = 3'd0, P_FETCH = 3'd1, P_DECODE = 3'd2,
                           P_EXEC = 3'd3, P_MEM = 3'd4, P_WB = 3'd5,
                           P_FAULT = 3'd6;

    logic          clk = 1'b0;
    logic          rst, run, imem_ack, dmem_ack;
    logic [6:0]    inst_op;
    logic          reg_wr_i, mem_rd_i, mem_wr_i;
    logic          imem_req, ir_we, pc_we, reg_wr_o, mem_rd_o, mem_wr_o;
    logic          retire, fault;
    logic [2:0]    state_o;
    logic [CW-1:0] cycle_cnt, instret_cnt;

    mc_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .imem_ack   (imem_ack),
        .dmem_ack   (dmem_ack),
        .inst_op    (inst_op),
        .reg_wr_i   (reg_wr_i),
        .mem_rd_i   (mem_rd_i),
        .mem_wr_i   (mem_wr_i),
        .imem_req   (imem_req),
        .ir_we      (ir_we),
        .pc_we      (pc_we),
        .reg_wr_o   (reg_wr_o),
        .mem_rd_o   (mem_rd_o),
        .mem_wr_o   (mem_wr_o),
        .retire     (retire),
        .fault      (fault),
        .state_o    (state_o),
        .cycle_cnt  (cycle_cnt),
        .instret_cnt(instret_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] st;     // phase the DUT is expected to be in this cycle
        logic       rst;
        logic       run;
        logic       ia;
        logic       da;
        logic [6:0] op;
        logic       rw;
        logic       mr;
        logic       mw;
    } entry_t;

    entry_t q[$];
    int     checks = 0;
    int     errors = 0;
    int     cyc_model = 0;
    int     ret_model = 0;

    logic [6:0] legal_ops [9] = '{7'b0110011, 7'b0010011, 7'b0000011,
                                  7'b0100011, 7'b1100011, 7'b1101111,
                                  7'b1100111, 7'b0110111, 7'b0010111};

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp,
                     $time);
        end
    endtask

    function automatic bit is_legal(input logic [6:0] op);
        for (int i = 0; i < 9; i++)
            if (legal_ops[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    // Entry with random values on every input; callers pin the inputs that
    // matter for the phase.
    function automatic entry_t mk(input logic [2:0] st);
        entry_t e;
        e.st  = st;
        e.rst = 1'b0;
        e.run = 1'($urandom_range(0, 1));
        e.ia  = 1'($urandom_range(0, 1));
        e.da  = 1'($urandom_range(0, 1));
        e.op  = 7'($urandom);
        e.rw  = 1'($urandom_range(0, 1));
        e.mr  = 1'($urandom_range(0, 1));
        e.mw  = 1'($urandom_range(0, 1));
        return e;
    endfunction

    task automatic emit(input entry_t e_in, inout int n, input int rst_at,
                        output bit hit);
        entry_t e = e_in;
        if (n == rst_at) e.rst = 1'b1;
        hit = e.rst;
        q.push_back(e);
        n++;
    endtask

    // After a reset the block sits in IDLE until run is seen.
    task automatic reset_tail();
        entry_t e;
        repeat ($urandom_range(0, 2)) begin
            e = mk(P_IDLE);
            e.run = 1'b0;
            q.push_back(e);
        end
        e = mk(P_IDLE);
        e.run = 1'b1;
        q.push_back(e);
    endtask

    // FAULT holds regardless of inputs until rst.
    task automatic fault_tail();
        entry_t e;
        repeat ($urandom_range(1, 3)) q.push_back(mk(P_FAULT));
        e = mk(P_FAULT);
        e.rst = 1'b1;
        q.push_back(e);
        reset_tail();
    endtask

    // One instruction starting in FETCH. id/dd: ack delays in cycles
    // (>= TO means the ack never comes). rst_at: cycle index of a reset
    // inside the instruction, or -1.
    task automatic gen_instr(input logic [6:0] op, input logic rw,
                             input logic mr, input logic mw, input int id,
                             input int dd, input logic wb_run,
                             input int rst_at);
        entry_t e;
        int     n = 0;
        bit     hit;
        for (int k = 0; k < TO; k++) begin
            e = mk(P_FETCH);
            e.ia = (k == id);
            emit(e, n, rst_at, hit);
            if (hit) begin reset_tail(); return; end
            if (e.ia) break;
        end
        if (id >= TO) begin fault_tail(); return; end

        e = mk(P_DECODE);
        e.op = op;
        emit(e, n, rst_at, hit);
        if (hit) begin reset_tail(); return; end
        if (!is_legal(op)) begin fault_tail(); return; end

        e = mk(P_EXEC);
        e.mr = mr;
        e.mw = mw;
        emit(e, n, rst_at, hit);
        if (hit) begin reset_tail(); return; end

        if (mr || mw) begin
            for (int k = 0; k < TO; k++) begin
                e = mk(P_MEM);
                e.mr = mr;
                e.mw = mw;
                e.da = (k == dd);
                emit(e, n, rst_at, hit);
                if (hit) begin reset_tail(); return; end
                if (e.da) break;
            end
            if (dd >= TO) begin fault_tail(); return; end
        end

        e = mk(P_WB);
        e.rw = rw;
        e.mr = mr;
        e.mw = mw;
        e.run = wb_run;
        emit(e, n, rst_at, hit);
        if (hit) begin reset_tail(); return; end
        if (!wb_run) reset_tail();
    endtask

    // Compare process body: one call per script cycle.
    task automatic compare_cycle(input entry_t e);
        check("state_o",   32'(state_o),  32'(e.st));
        check("imem_req",  32'(imem_req), 32'(e.st == P_FETCH));
        check("ir_we",     32'(ir_we),    32'(e.st == P_FETCH && e.ia));
        check("pc_we",     32'(pc_we),    32'(e.st == P_WB));
        check("retire",    32'(retire),   32'(e.st == P_WB));
        check("reg_wr_o",  32'(reg_wr_o), 32'(e.st == P_WB && e.rw));
        check("mem_rd_o",  32'(mem_rd_o), 32'(e.st == P_MEM && e.mr));
        check("mem_wr_o",  32'(mem_wr_o), 32'(e.st == P_MEM && e.mw));
        check("fault",     32'(fault),    32'(e.st == P_FAULT));
        check("cycle_cnt", 32'(cycle_cnt),   32'(cyc_model % (1 << CW)));
        check("instret",   32'(instret_cnt), 32'(ret_model % (1 << CW)));
    endtask

    task automatic drain();
        entry_t e;
        while (q.size() > 0) begin
            e = q.pop_front();
            @(negedge clk);
            rst      = e.rst;
            run      = e.run;
            imem_ack = e.ia;
            dmem_ack = e.da;
            inst_op  = e.op;
            reg_wr_i = e.rw;
            mem_rd_i = e.mr;
            mem_wr_i = e.mw;
            #3;
            compare_cycle(e);
            if (e.rst) begin
                cyc_model = 0;
                ret_model = 0;
            end else begin
                if (e.st != P_IDLE && e.st != P_FAULT) cyc_model++;
                if (e.st == P_WB) ret_model++;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        entry_t e;
        logic [6:0] op;
        logic rw, mr, mw;
        int id, dd, ra;

        rst = 1'b1; run = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
        inst_op = '0; reg_wr_i = 1'b0; mem_rd_i = 1'b0; mem_wr_i = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state, then ADDI x1,x0,5 with immediate acks.
        e = mk(P_IDLE);
        e.run = 1'b1;
        q.push_back(e);
        gen_instr(7'b0010011, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0, -1);
        drain();
        check("addi_cycle_cnt", 32'(cycle_cnt),   32'd4);
        check("addi_instret",   32'(instret_cnt), 32'd1);
        check("addi_idle",      32'(state_o),     32'd0);

        // SW with dmem_ack on the fourth MEM cycle: 8 active cycles.
        gen_instr(7'b0100011, 1'b0, 1'b0, 1'b1, 0, 3, 1'b0, -1);
        drain();
        check("sw_cycle_cnt", 32'(cycle_cnt),   32'd12);
        check("sw_instret",   32'(instret_cnt), 32'd2);

        // imem_ack never arrives: 16 FETCH cycles, then FAULT.
        for (int k = 0; k < TO; k++) begin
            e = mk(P_FETCH);
            e.ia = 1'b0;
            q.push_back(e);
        end
        q.push_back(mk(P_FAULT));
        drain();
        check("to_state", 32'(state_o),   32'd6);
        check("to_fault", 32'(fault),     32'd1);
        check("to_cycle", 32'(cycle_cnt), 32'd28);
        fault_tail();
        drain();

        // Illegal opcode 0000000.
        gen_instr(7'b0000000, 1'b1, 1'b0, 1'b0, 0, 0, 1'b1, -1);
        drain();

        // LW with run low at write-back, then IDLE with frozen counters.
        gen_instr(7'b0000011, 1'b1, 1'b1, 1'b0, 1, 2, 1'b0, -1);
        drain();

        // Reset on the second MEM cycle of an LW.
        gen_instr(7'b0000011, 1'b1, 1'b1, 1'b0, 0, 3, 1'b1, 4);
        drain();
        check("rstmem_state",   32'(state_o),     32'd0);
        check("rstmem_cycle",   32'(cycle_cnt),   32'd0);
        check("rstmem_instret", 32'(instret_cnt), 32'd0);

        // Ack exactly on the last permitted cycle: still a fetch.
        gen_instr(7'b0110011, 1'b1, 1'b0, 1'b0, TO - 1, 0, 1'b1, -1);
        gen_instr(7'b0100011, 1'b0, 1'b0, 1'b1, 0, TO - 1, 1'b1, -1);
        drain();

        // Randomized instruction stream.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                do op = 7'($urandom); while (is_legal(op));
            end else begin
                op = legal_ops[$urandom_range(0, 8)];
            end
            mr = (op == 7'b0000011);
            mw = (op == 7'b0100011);
            rw = !(op == 7'b0100011 || op == 7'b1100011);
            if ($urandom_range(0, 9) == 0) rw = !rw;
            id = ($urandom_range(0, 9) < 7) ? 0 : $urandom_range(1, TO - 1);
            if ($urandom_range(0, 39) == 0) id = TO;
            dd = ($urandom_range(0, 9) < 6) ? 0 : $urandom_range(1, TO - 1);
            if ($urandom_range(0, 39) == 0) dd = TO;
            ra = ($urandom_range(0, 29) == 0) ? int'($urandom_range(0, 8)) : -1;
            gen_instr(op, rw, mr, mw, id, dd,
                      1'($urandom_range(0, 9) < 7), ra);
            drain();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
